// File: rtl/vend_seq_ctrl.sv
// Vending sequencing controller: credit accumulation, product selection, dispense, change/refund.
// Optional inactivity auto-refund in COLLECT is compiled in with `define TIMEOUT_REFUND_EN.
module vend_seq_ctrl #(
   parameter int unsigned PRICE_A    = 20,
   parameter int unsigned PRICE_B    = 15,
   parameter int unsigned PRICE_C    = 30,
   parameter int unsigned MAX_CREDIT = 40
`ifdef TIMEOUT_REFUND_EN
   ,
   parameter int unsigned TIMEOUT    = 15
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [4:0] coin,
   input  logic       sel_valid,
   input  logic [1:0] sel,
   input  logic       cancel,
   output logic [5:0] credit,
   output logic       busy,
   output logic       dispense,
   output logic [1:0] prod_id,
   output logic       change_5,
   output logic       coin_reject,
   output logic       short_funds
);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      VEND,
      CHANGE,
      REFUND
   } state_t;

   state_t     state, state_d;
   logic [5:0] credit_d;
   logic       busy_d, dispense_d, change_d, reject_d, short_d;
   logic [1:0] prod_id_d;
   logic [5:0] price;
   logic [6:0] coin_sum;
   logic       coin_legal, coin_fits, coin_ok, take_refund;

`ifdef TIMEOUT_REFUND_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer, timer_d;
   logic          timeout_hit;
`endif

   always_comb begin
      case (sel)
         2'd0:    price = 6'(PRICE_A);
         2'd1:    price = 6'(PRICE_B);
         default: price = 6'(PRICE_C);
      endcase
   end

   assign coin_sum   = {1'b0, credit} + {2'b00, coin};
   assign coin_legal = (coin == 5'd5) || (coin == 5'd10);
   assign coin_fits  = coin_sum <= 7'(MAX_CREDIT);

   // Timeout behaves like a cancel, but only on a cycle with no other request pending.
`ifdef TIMEOUT_REFUND_EN
   assign timeout_hit = (state == COLLECT) && (timer == TW'(TIMEOUT - 1))
                        && !coin_valid && !sel_valid;
   assign take_refund = cancel || timeout_hit;
`else
   assign take_refund = cancel;
`endif

   // Next-state and next-output logic; every pulse output defaults low each cycle.
   always_comb begin
      state_d    = state;
      credit_d   = credit;
      prod_id_d  = prod_id;
      dispense_d = 1'b0;
      change_d   = 1'b0;
      reject_d   = 1'b0;
      short_d    = 1'b0;
      coin_ok    = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            if (take_refund && state == COLLECT) begin
               state_d  = REFUND;
               change_d = 1'b1;
               credit_d = credit - 6'd5;
               reject_d = coin_valid;
            end else if (sel_valid && sel != 2'd3) begin
               if (state == COLLECT && credit >= price) begin
                  state_d    = VEND;
                  dispense_d = 1'b1;
                  prod_id_d  = sel;
                  credit_d   = credit - price;
               end else begin
                  short_d = 1'b1;
               end
               reject_d = coin_valid;
            end else if (coin_valid) begin
               if (coin_legal && coin_fits) begin
                  coin_ok  = 1'b1;
                  credit_d = coin_sum[5:0];
                  state_d  = COLLECT;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         VEND, CHANGE, REFUND: begin
            reject_d = coin_valid;
            if (credit != 6'd0) begin
               state_d  = (state == REFUND) ? REFUND : CHANGE;
               change_d = 1'b1;
               credit_d = credit - 6'd5;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == VEND) || (state_d == CHANGE) || (state_d == REFUND);
   end

   // Inactivity counter saturates at the trip value so a rejected coin only delays the refund.
`ifdef TIMEOUT_REFUND_EN
   always_comb begin
      timer_d = '0;
      if (state == COLLECT && state_d == COLLECT && !coin_ok && !short_d
          && timer != TW'(TIMEOUT - 1))
         timer_d = timer + 1'b1;
      else if (state == COLLECT && state_d == COLLECT && !coin_ok && !short_d)
         timer_d = timer;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         credit      <= '0;
         busy        <= 1'b0;
         dispense    <= 1'b0;
         prod_id     <= '0;
         change_5    <= 1'b0;
         coin_reject <= 1'b0;
         short_funds <= 1'b0;
`ifdef TIMEOUT_REFUND_EN
         timer       <= '0;
`endif
      end else begin
         state       <= state_d;
         credit      <= credit_d;
         busy        <= busy_d;
         dispense    <= dispense_d;
         prod_id     <= prod_id_d;
         change_5    <= change_d;
         coin_reject <= reject_d;
         short_funds <= short_d;
`ifdef TIMEOUT_REFUND_EN
         timer       <= timer_d;
`endif
      end
   end

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Directed, table-driven bench for vend_seq_ctrl with a few multi-cycle hand sequences.
module tb_vend_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, coin_valid, sel_valid, cancel;
   logic [4:0] coin;
   logic [1:0] sel;
   logic [5:0] credit;
   logic       busy, dispense, change_5, coin_reject, short_funds;
   logic [1:0] prod_id;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vend_seq_ctrl dut (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
      .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
      .credit(credit), .busy(busy), .dispense(dispense), .prod_id(prod_id),
      .change_5(change_5), .coin_reject(coin_reject), .short_funds(short_funds)
   );

   typedef struct {
      string      nm;
      logic       rst;
      logic       cv;
      logic [4:0] coin;
      logic       sv;
      logic [1:0] sel;
      logic       cn;
      logic [5:0] cr;
      logic       busy;
      logic       disp;
      logic [1:0] pid;
      logic       ch;
      logic       rej;
      logic       sf;
   } vec_t;

   vec_t vecs[$];

   function automatic void addV(string nm, logic r, logic cv, logic [4:0] c, logic sv,
                                logic [1:0] s, logic cn, logic [5:0] cr, logic b,
                                logic d, logic [1:0] p, logic ch, logic rj, logic sf);
      vec_t v;
      v.nm = nm; v.rst = r; v.cv = cv; v.coin = c; v.sv = sv; v.sel = s; v.cn = cn;
      v.cr = cr; v.busy = b; v.disp = d; v.pid = p; v.ch = ch; v.rej = rj; v.sf = sf;
      vecs.push_back(v);
   endfunction

   function automatic vec_t idleV();
      vec_t v;
      v.nm = "idle"; v.rst = 0; v.cv = 0; v.coin = 0; v.sv = 0; v.sel = 0; v.cn = 0;
      v.cr = 0; v.busy = 0; v.disp = 0; v.pid = 0; v.ch = 0; v.rej = 0; v.sf = 0;
      return v;
   endfunction

   // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst = v.rst; coin_valid = v.cv; coin = v.coin;
      sel_valid = v.sv; sel = v.sel; cancel = v.cn;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v);
      total++;
      if ({credit, busy, dispense, prod_id, change_5, coin_reject, short_funds} !==
          {v.cr, v.busy, v.disp, v.pid, v.ch, v.rej, v.sf}) begin
         bad++;
         $display("[TB] FAIL %s: got cr=%0d busy=%b disp=%b pid=%0d ch=%b rej=%b sf=%b, want cr=%0d busy=%b disp=%b pid=%0d ch=%b rej=%b sf=%b",
                  v.nm, credit, busy, dispense, prod_id, change_5, coin_reject, short_funds,
                  v.cr, v.busy, v.disp, v.pid, v.ch, v.rej, v.sf);
      end
   endtask

   task automatic checkValue(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   initial begin
      vec_t v;
      int   pulses;
      bit   done;

      rst = 1'b1; coin_valid = 1'b0; coin = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0;

      //   name                r cv coin sv s cn   cr b d p ch rj sf
      addV("reset",            1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      addV("t1 coin10 a",      0, 1, 10, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0);
      addV("t1 coin10 b",      0, 1, 10, 0, 0, 0,  20, 0, 0, 0, 0, 0, 0);
      addV("t1 sel0 vend",     0, 0,  0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0);
      addV("t1 back idle",     0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      addV("t2 coin10 a",      0, 1, 10, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0);
      addV("t2 coin10 b",      0, 1, 10, 0, 0, 0,  20, 0, 0, 0, 0, 0, 0);
      addV("t2 coin10 c",      0, 1, 10, 0, 0, 0,  30, 0, 0, 0, 0, 0, 0);
      addV("t2 sel1 vend",     0, 0,  0, 1, 1, 0,  15, 1, 1, 1, 0, 0, 0);
      addV("t2 change 1",      0, 0,  0, 0, 0, 0,  10, 1, 0, 1, 1, 0, 0);
      addV("t2 change 2",      0, 0,  0, 0, 0, 0,   5, 1, 0, 1, 1, 0, 0);
      addV("t2 change 3",      0, 0,  0, 0, 0, 0,   0, 1, 0, 1, 1, 0, 0);
      addV("t2 back idle",     0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
      addV("t3 coin5",         0, 1,  5, 0, 0, 0,   5, 0, 0, 1, 0, 0, 0);
      addV("t3 sel0 short",    0, 0,  0, 1, 0, 0,   5, 0, 0, 1, 0, 0, 1);
      addV("t3 cancel",        0, 0,  0, 0, 0, 1,   0, 1, 0, 1, 1, 0, 0);
      addV("t3 back idle",     0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
      addV("t4 coin7 reject",  0, 1,  7, 0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
      addV("t4 coin10 a",      0, 1, 10, 0, 0, 0,  10, 0, 0, 1, 0, 0, 0);
      addV("t4 coin10 b",      0, 1, 10, 0, 0, 0,  20, 0, 0, 1, 0, 0, 0);
      addV("t4 coin10 c",      0, 1, 10, 0, 0, 0,  30, 0, 0, 1, 0, 0, 0);
      addV("t4 coin10 to max", 0, 1, 10, 0, 0, 0,  40, 0, 0, 1, 0, 0, 0);
      addV("t4 overflow5",     0, 1,  5, 0, 0, 0,  40, 0, 0, 1, 0, 1, 0);
      addV("t4 sel2 vend",     0, 0,  0, 1, 2, 0,  10, 1, 1, 2, 0, 0, 0);
      addV("t4 coin in chg a", 0, 1,  5, 0, 0, 0,   5, 1, 0, 2, 1, 1, 0);
      addV("t4 busy ignores",  0, 1,  5, 1, 0, 1,   0, 1, 0, 2, 1, 1, 0);
      addV("t4 back idle",     0, 0,  0, 0, 0, 0,   0, 0, 0, 2, 0, 0, 0);
      addV("t5 coin10 a",      0, 1, 10, 0, 0, 0,  10, 0, 0, 2, 0, 0, 0);
      addV("t5 coin10 b",      0, 1, 10, 0, 0, 0,  20, 0, 0, 2, 0, 0, 0);
      addV("t5 cancel+sel+cn", 0, 1,  5, 1, 0, 1,  15, 1, 0, 2, 1, 1, 0);
      addV("t5 pulse 2",       0, 0,  0, 0, 0, 0,  10, 1, 0, 2, 1, 0, 0);
      addV("t5 reset mid",     1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      addV("t5 pulses stop",   0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      addV("idle sel short",   0, 0,  0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1);
      addV("idle cancel nop",  0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
      addV("c coin5",          0, 1,  5, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0);
      addV("c sel3 ignored",   0, 0,  0, 1, 3, 0,   5, 0, 0, 0, 0, 0, 0);
      addV("c cancel",         0, 0,  0, 0, 0, 1,   0, 1, 0, 0, 1, 0, 0);
      addV("c back idle",      0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      addV("b coin10 a",       0, 1, 10, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0);
      addV("b coin10 b",       0, 1, 10, 0, 0, 0,  20, 0, 0, 0, 0, 0, 0);
      addV("b coin10 c",       0, 1, 10, 0, 0, 0,  30, 0, 0, 0, 0, 0, 0);
      addV("b coin5 to 35",    0, 1,  5, 0, 0, 0,  35, 0, 0, 0, 0, 0, 0);
      addV("b coin10 over",    0, 1, 10, 0, 0, 0,  35, 0, 0, 0, 0, 1, 0);
      addV("b coin5 to 40",    0, 1,  5, 0, 0, 0,  40, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end

      // Full refund from the ceiling: eight pulses, then busy drops within a bounded window.
      v = idleV();
      v.cn = 1'b1;
      applyStimulus(v);
      pulses = change_5 ? 1 : 0;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         applyStimulus(idleV());
         if (change_5) pulses++;
         if (!busy) done = 1'b1;
      end
      checkValue("refund40 finished", int'(done), 1);
      checkValue("refund40 pulses", pulses, 8);
      checkValue("refund40 credit", int'(credit), 0);

      // Credit parked in COLLECT with no activity.
      v = idleV();
      v.cv = 1'b1; v.coin = 5'd10;
      applyStimulus(v);
      checkValue("park coin10", int'(credit), 10);
`ifdef TIMEOUT_REFUND_EN
      for (int i = 0; i < 14; i++) begin
         applyStimulus(idleV());
         checkValue("timeout wait credit", int'(credit), 10);
      end
      applyStimulus(idleV());
      checkValue("timeout refund pulse1", int'({busy, change_5}), 3);
      checkValue("timeout refund credit1", int'(credit), 5);
      applyStimulus(idleV());
      checkValue("timeout refund pulse2", int'({busy, change_5}), 3);
      checkValue("timeout refund credit2", int'(credit), 0);
      applyStimulus(idleV());
      checkValue("timeout back idle", int'({busy, change_5}), 0);
`else
      for (int i = 0; i < 100; i++) begin
         applyStimulus(idleV());
         checkValue("hold credit", int'(credit), 10);
         checkValue("hold quiet", int'({busy, change_5}), 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
